// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode constants and operand type for the ALU issue path
//
// Purpose : opcode encodings understood by the downstream 8-bit ALU, the ALU
//           data width, and the packed operand bundle {ctrl, x, y} that the
//           issue stage wraps together with a tag for its command FIFO.
// Ports   : none (package).
package alu_pkg;

   localparam int ALU_W  = 8;
   localparam int CTRL_W = 4;

   localparam logic [CTRL_W-1:0] OP_ADD = 4'd0;
   localparam logic [CTRL_W-1:0] OP_SUB = 4'd1;
   localparam logic [CTRL_W-1:0] OP_AND = 4'd2;
   localparam logic [CTRL_W-1:0] OP_OR  = 4'd3;
   localparam logic [CTRL_W-1:0] OP_NOT = 4'd4;
   localparam logic [CTRL_W-1:0] OP_XOR = 4'd5;
   localparam logic [CTRL_W-1:0] OP_NOR = 4'd6;
   localparam logic [CTRL_W-1:0] OP_SHL = 4'd7;
   localparam logic [CTRL_W-1:0] OP_SHR = 4'd8;
   localparam logic [CTRL_W-1:0] OP_ASR = 4'd9;
   localparam logic [CTRL_W-1:0] OP_ROL = 4'd10;
   localparam logic [CTRL_W-1:0] OP_ROR = 4'd11;
   localparam logic [CTRL_W-1:0] OP_EQ  = 4'd12;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [ALU_W-1:0]  x;
      logic [ALU_W-1:0]  y;
   } alu_op_t;

   localparam int OP_BITS = $bits(alu_op_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO for the ALU issue stage
//
// Purpose : DEPTH-entry first-word-fall-through FIFO; pop_data always shows
//           the head entry while not empty.
// Ports   : clk, reset     - clock, asynchronous active-high reset
//           push/push_data - write one entry (ignored while full)
//           pop/pop_data   - drop the head entry (ignored while empty)
//           full, empty    - occupancy flags
//           count          - number of stored entries, 0..DEPTH
module alu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 24
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic [W-1:0]           pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == (PW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage carries no reset: entries are only observable once written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers are exactly PW bits wide, so the increment wraps modulo DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - buffered, two-register issue stage in front of the combinational ALU
//
// Purpose : accepts tagged ALU commands, queues them, drives them onto
//           registered ALU operand lines (S1) and captures the ALU answer
//           one cycle later into a result register (S2) with backpressure.
// Ports   : clk, reset                       - clock, asynchronous active-high reset
//           cmd_valid/cmd_ready              - command handshake
//           cmd_ctrl, cmd_x, cmd_y, cmd_tag  - command payload
//           alu_ctrl, alu_x, alu_y           - registered operands to the ALU
//           alu_out, alu_carry               - combinational ALU answer
//           res_valid/res_ready              - result handshake
//           res_data, res_carry, res_zero, res_tag - captured result
//           fifo_count                       - command FIFO occupancy
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [CTRL_W-1:0]      cmd_ctrl,
   input  logic [ALU_W-1:0]       cmd_x,
   input  logic [ALU_W-1:0]       cmd_y,
   input  logic [TAG_W-1:0]       cmd_tag,
   output logic [CTRL_W-1:0]      alu_ctrl,
   output logic [ALU_W-1:0]       alu_x,
   output logic [ALU_W-1:0]       alu_y,
   input  logic [ALU_W-1:0]       alu_out,
   input  logic                   alu_carry,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [ALU_W-1:0]       res_data,
   output logic                   res_carry,
   output logic                   res_zero,
   output logic [TAG_W-1:0]       res_tag,
   output logic [$clog2(DEPTH):0] fifo_count
);

   typedef struct packed {
      alu_op_t          op;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   cmd_t             push_cmd;
   cmd_t             head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             s1_v;
   logic [TAG_W-1:0] s1_tag;
   logic             s2_adv;
   logic             s1_free;
   logic             s1_load;

   assign push_cmd = {cmd_ctrl, cmd_x, cmd_y, cmd_tag};

   // Ready comes from occupancy alone, never from a same-cycle pop, so the
   // upstream handshake has no combinational path back from res_ready.
   assign cmd_ready = !fifo_full;

   assign s2_adv  = s1_v && (!res_valid || res_ready);
   assign s1_free = !s1_v || s2_adv;
   assign s1_load = s1_free && !fifo_empty;

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(cmd_t))
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (cmd_valid && cmd_ready),
      .push_data (push_cmd),
      .pop       (s1_load),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // S1: operands stay put while idle, only the valid bit drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_v     <= 1'b0;
         s1_tag   <= '0;
         alu_ctrl <= '0;
         alu_x    <= '0;
         alu_y    <= '0;
      end else if (s1_load) begin
         s1_v     <= 1'b1;
         s1_tag   <= head.tag;
         alu_ctrl <= head.op.ctrl;
         alu_x    <= head.op.x;
         alu_y    <= head.op.y;
      end else if (s1_free) begin
         s1_v     <= 1'b0;
      end
   end

   // S2: captures the ALU answer for the operands currently held in S1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_carry <= 1'b0;
         res_zero  <= 1'b0;
         res_tag   <= '0;
      end else if (s2_adv) begin
         res_valid <= 1'b1;
         res_data  <= alu_out;
         res_carry <= alu_carry;
         res_zero  <= (alu_out == '0);
         res_tag   <= s1_tag;
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule
